// File: rtl/cmult_dump_acc.sv
// Complex integrate-and-dump stage for the coefficient multiplier output.
// Sums N valid I/Q products, then emits one arithmetically shifted,
// saturated complex result with a single-cycle valid strobe.
module cmult_dump_acc #(
    parameter int unsigned DW    = 16,
    parameter int unsigned LEN_W = 8,
    parameter int unsigned AW    = DW + LEN_W,
    parameter int unsigned SHIFT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 cont,
    input  logic [LEN_W-1:0]     dump_len,
    input  logic                 din_valid,
    input  logic signed [DW-1:0] din_i,
    input  logic signed [DW-1:0] din_q,
    output logic signed [DW-1:0] dout_i,
    output logic signed [DW-1:0] dout_q,
    output logic                 dout_valid,
    output logic                 sat,
    output logic                 busy
);

    typedef enum logic {StIdle, StAccum} state_e;

    // Output clamp bounds expressed at accumulator width.
    localparam logic signed [AW-1:0] SatMax = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SatMin = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_e                 state;
    logic [LEN_W-1:0]       len_r;
    logic [LEN_W-1:0]       cnt;
    logic signed [AW-1:0]   acc_i;
    logic signed [AW-1:0]   acc_q;

    logic signed [AW-1:0]   sum_i;
    logic signed [AW-1:0]   sum_q;
    logic signed [AW-1:0]   sh_i;
    logic signed [AW-1:0]   sh_q;
    logic signed [DW-1:0]   clamp_i;
    logic signed [DW-1:0]   clamp_q;
    logic                   sat_i;
    logic                   sat_q;

    // Running sum including the current sample, scaled and clamped for a dump.
    always_comb begin
        sum_i   = acc_i + {{(AW-DW){din_i[DW-1]}}, din_i};
        sum_q   = acc_q + {{(AW-DW){din_q[DW-1]}}, din_q};
        sh_i    = sum_i >>> SHIFT;
        sh_q    = sum_q >>> SHIFT;
        sat_i   = 1'b0;
        sat_q   = 1'b0;
        clamp_i = sh_i[DW-1:0];
        clamp_q = sh_q[DW-1:0];
        if (sh_i > SatMax) begin
            clamp_i = SatMax[DW-1:0];
            sat_i   = 1'b1;
        end else if (sh_i < SatMin) begin
            clamp_i = SatMin[DW-1:0];
            sat_i   = 1'b1;
        end
        if (sh_q > SatMax) begin
            clamp_q = SatMax[DW-1:0];
            sat_q   = 1'b1;
        end else if (sh_q < SatMin) begin
            clamp_q = SatMin[DW-1:0];
            sat_q   = 1'b1;
        end
    end

    // Window FSM, accumulators and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= StIdle;
            len_r      <= '0;
            cnt        <= '0;
            acc_i      <= '0;
            acc_q      <= '0;
            dout_i     <= '0;
            dout_q     <= '0;
            dout_valid <= 1'b0;
            sat        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            sat        <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        len_r <= dump_len;
                        cnt   <= '0;
                        acc_i <= '0;
                        acc_q <= '0;
                        state <= StAccum;
                        busy  <= 1'b1;
                    end
                end
                StAccum: begin
                    if (start) begin
                        // Abort: restart the window, any coincident sample is dropped.
                        len_r <= dump_len;
                        cnt   <= '0;
                        acc_i <= '0;
                        acc_q <= '0;
                    end else if (din_valid) begin
                        if (cnt == len_r) begin
                            dout_i     <= clamp_i;
                            dout_q     <= clamp_q;
                            dout_valid <= 1'b1;
                            sat        <= sat_i | sat_q;
                            cnt        <= '0;
                            acc_i      <= '0;
                            acc_q      <= '0;
                            if (!cont) begin
                                state <= StIdle;
                                busy  <= 1'b0;
                            end
                        end else begin
                            acc_i <= sum_i;
                            acc_q <= sum_q;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cmult_dump_acc.sv
// Directed bench for cmult_dump_acc: one SHIFT=8 and one SHIFT=0 instance
// share the same stimulus; each scenario checks the instance it targets.
module tb_cmult_dump_acc;

    logic               clk;
    logic               reset;
    logic               start;
    logic               cont;
    logic [7:0]         dump_len;
    logic               din_valid;
    logic signed [15:0] din_i;
    logic signed [15:0] din_q;

    logic signed [15:0] dout_i8, dout_q8, dout_i0, dout_q0;
    logic               dout_valid8, sat8, busy8;
    logic               dout_valid0, sat0, busy0;

    int n_tests;
    int n_fail;

    cmult_dump_acc #(.DW(16), .LEN_W(8), .AW(24), .SHIFT(8)) u_dut8 (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cont       (cont),
        .dump_len   (dump_len),
        .din_valid  (din_valid),
        .din_i      (din_i),
        .din_q      (din_q),
        .dout_i     (dout_i8),
        .dout_q     (dout_q8),
        .dout_valid (dout_valid8),
        .sat        (sat8),
        .busy       (busy8)
    );

    cmult_dump_acc #(.DW(16), .LEN_W(8), .AW(24), .SHIFT(0)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cont       (cont),
        .dump_len   (dump_len),
        .din_valid  (din_valid),
        .din_i      (din_i),
        .din_q      (din_q),
        .dout_i     (dout_i0),
        .dout_q     (dout_q0),
        .dout_valid (dout_valid0),
        .sat        (sat0),
        .busy       (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] len, input logic c);
        start     = 1'b1;
        dump_len  = len;
        cont      = c;
        din_valid = 1'b0;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        int strobes;
        logic [6:0] gap_pat;
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b0;
        start     = 1'b0;
        cont      = 1'b0;
        dump_len  = '0;
        din_valid = 1'b0;
        din_i     = '0;
        din_q     = '0;
        tick();
        tick();

        // Reset state
        check_eq("rst_dout_i", dout_i8, 0);
        check_eq("rst_dout_q", dout_q8, 0);
        check_eq("rst_valid", dout_valid8, 0);
        check_eq("rst_sat", sat8, 0);
        check_eq("rst_busy", busy8, 0);
        reset = 1'b1;
        tick();

        // Basic dump, SHIFT=8: 4 x (1000, -1000) -> 15, -16
        pulse_start(8'd3, 1'b0);
        check_eq("basic_busy_on", busy8, 1);
        din_valid = 1'b1;
        din_i = 16'sd1000;
        din_q = -16'sd1000;
        strobes = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            strobes += int'(dout_valid8);
        end
        check_eq("basic_no_early", strobes, 0);
        tick();
        check_eq("basic_valid", dout_valid8, 1);
        check_eq("basic_dout_i", dout_i8, 15);
        check_eq("basic_dout_q", dout_q8, -16);
        check_eq("basic_sat", sat8, 0);
        check_eq("basic_busy_off", busy8, 0);
        tick();
        check_eq("basic_strobe_1cyc", dout_valid8, 0);
        check_eq("basic_hold_i", dout_i8, 15);
        strobes = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            strobes += int'(dout_valid8);
        end
        check_eq("idle_ignores_din", strobes, 0);
        check_eq("idle_busy", busy8, 0);

        // Gapped input: valid = 1,0,1,0,0,1,1; invalid data 5000
        pulse_start(8'd3, 1'b0);
        gap_pat = 7'b1100101;
        strobes = 0;
        for (int k = 0; k < 7; k++) begin
            din_valid = gap_pat[k];
            din_i = gap_pat[k] ? 16'sd1000 : 16'sd5000;
            din_q = gap_pat[k] ? -16'sd1000 : 16'sd5000;
            tick();
            if (k < 6) strobes += int'(dout_valid8);
        end
        check_eq("gap_no_early", strobes, 0);
        check_eq("gap_valid", dout_valid8, 1);
        check_eq("gap_dout_i", dout_i8, 15);
        check_eq("gap_dout_q", dout_q8, -16);
        din_valid = 1'b0;
        tick();

        // Continuous, SHIFT=0: pairs (1,2),(3,4),(5,6) -> 3, 7, 11
        pulse_start(8'd1, 1'b1);
        din_valid = 1'b1;
        din_q = '0;
        for (int k = 1; k <= 6; k++) begin
            din_i = 16'(k);
            tick();
            check_eq("cont_busy", busy0, 1);
            if (k % 2 == 0) begin
                check_eq("cont_valid", dout_valid0, 1);
                check_eq("cont_dout_i", dout_i0, 2 * k - 1);
            end else begin
                check_eq("cont_gap", dout_valid0, 0);
            end
        end
        din_valid = 1'b0;
        cont = 1'b0;
        tick();

        // Saturation: 2 x (30000, -32768)
        pulse_start(8'd1, 1'b0);
        din_valid = 1'b1;
        din_i = 16'sd30000;
        din_q = -16'sd32768;
        tick();
        tick();
        check_eq("sat0_valid", dout_valid0, 1);
        check_eq("sat0_dout_i", dout_i0, 32767);
        check_eq("sat0_dout_q", dout_q0, -32768);
        check_eq("sat0_flag", sat0, 1);
        check_eq("sat8_dout_i", dout_i8, 234);
        check_eq("sat8_dout_q", dout_q8, -256);
        check_eq("sat8_flag", sat8, 0);
        din_valid = 1'b0;
        tick();
        check_eq("sat_flag_clears", sat0, 0);

        // Full-scale window, SHIFT=8: 256 x (-32768, 32767)
        pulse_start(8'd255, 1'b0);
        din_valid = 1'b1;
        din_i = -16'sd32768;
        din_q = 16'sd32767;
        strobes = 0;
        for (int k = 0; k < 255; k++) begin
            tick();
            strobes += int'(dout_valid8);
        end
        check_eq("full_no_early", strobes, 0);
        tick();
        check_eq("full_valid", dout_valid8, 1);
        check_eq("full_dout_i", dout_i8, -32768);
        check_eq("full_dout_q", dout_q8, 32767);
        check_eq("full_sat", sat8, 0);
        din_valid = 1'b0;
        tick();

        // Abort: 2 samples, restart, then 4 x 100 -> single dump of 1
        pulse_start(8'd3, 1'b0);
        din_valid = 1'b1;
        din_i = 16'sd100;
        din_q = '0;
        strobes = 0;
        tick();
        tick();
        strobes += int'(dout_valid8);
        pulse_start(8'd3, 1'b0);
        strobes += int'(dout_valid8);
        din_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            strobes += int'(dout_valid8);
        end
        check_eq("abort_strobes", strobes, 1);
        check_eq("abort_valid_last", dout_valid8, 1);
        check_eq("abort_dout_i", dout_i8, 1);
        din_valid = 1'b0;
        tick();

        // start coinciding with a last sample wins: no dump
        pulse_start(8'd1, 1'b0);
        din_valid = 1'b1;
        din_i = 16'sd7;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_wins_nodump", dout_valid0, 0);
        check_eq("start_wins_busy", busy0, 1);
        din_i = 16'sd9;
        tick();
        tick();
        check_eq("start_wins_fresh", dout_i0, 18);
        din_valid = 1'b0;
        tick();

        // Reset mid-window
        pulse_start(8'd3, 1'b0);
        din_valid = 1'b1;
        din_i = 16'sd1000;
        din_q = 16'sd1000;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("midrst_dout_i", dout_i8, 0);
        check_eq("midrst_dout_q", dout_q8, 0);
        check_eq("midrst_valid", dout_valid8, 0);
        check_eq("midrst_busy", busy8, 0);
        tick();
        reset = 1'b1;
        strobes = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            strobes += int'(dout_valid8) + int'(busy8);
        end
        check_eq("postrst_idle", strobes, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cmult_dump_acc.md
# cmult_dump_acc

Complex integrate-and-dump stage directly downstream of the complex coefficient multiplier. It accumulates the multiplier's 16-bit I/Q products over a programmable window of N valid samples. At the end of each window it emits one scaled, saturated 16-bit complex result with a single-cycle valid strobe. Typical uses are correlator despreading and channel-estimate averaging ahead of the detection logic.

## Interface
- DW, 16: input/output sample width (two's complement).
- LEN_W, 8: width of the window-length field; max window = 2^LEN_W samples.
- AW, DW+LEN_W (24): accumulator width. Sized so the sum cannot wrap.
- SHIFT, 8: arithmetic right shift applied to the accumulator before saturation to DW.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: latch dump_len, clear the accumulator, open a window.
- cont  in  1  continuous mode: after a dump, immediately open the next window.
- dump_len  in  LEN_W  window length minus 1 (N = dump_len+1); sampled only on start.
- din_valid  in  1  din_i/din_q carry a valid product this cycle.
- din_i  in  DW  in-phase product from the multiplier.
- din_q  in  DW  quadrature product from the multiplier.
- dout_i  out  DW  scaled, saturated I sum; held between dumps.
- dout_q  out  DW  scaled, saturated Q sum; held between dumps.
- dout_valid  out  1  one-cycle strobe: dout_i/dout_q updated.
- sat  out  1  valid with dout_valid: I or Q saturated in this dump.
- busy  out  1  window open (state ACCUM).

## Operation
- States: IDLE, ACCUM.
- IDLE, start=1:
  - len_r <= dump_len; acc_i, acc_q, cnt <= 0.
  - Go to ACCUM. No sample is accepted in the start cycle.
- ACCUM, din_valid=0: hold all state.
- ACCUM, din_valid=1, cnt<len_r:
  - acc_i += sign-extended din_i; acc_q += sign-extended din_q.
  - cnt += 1.
- ACCUM, din_valid=1, cnt==len_r (last sample):
  - Form s = acc + din at AW bits, then sh = s >>> SHIFT (floor, no rounding).
  - Clamp sh to [-2^(DW-1), 2^(DW-1)-1]; register the result into dout.
  - dout_valid <= 1. sat <= 1 if either I or Q was clamped, else 0.
  - acc, cnt <= 0.
  - Next state is ACCUM if cont=1, otherwise IDLE. len_r is retained.
- start=1 while in ACCUM aborts the window: reload len_r, clear acc/cnt, and stay in ACCUM. No dump occurs. If the same cycle is also a last-sample cycle, start wins: no dump, and that sample is discarded.
- dout_i/dout_q hold their value until the next dump. dout_valid and sat are zero in every non-dump cycle.
- The accumulator cannot overflow for N ≤ 2^LEN_W. The only saturation point is the output clamp.

## Timing
- Reset (async assert, sync release):
  - State IDLE; acc, cnt, len_r = 0.
  - dout_i = dout_q = 0; dout_valid = sat = busy = 0.
- busy is registered: 1 from the cycle after start until the cycle after the last sample (non-cont mode). It remains 1 in cont mode.
- Latency: dout_valid is high exactly one cycle after the clock edge that samples the last valid input.
- Continuous mode is gapless. A valid sample on the cycle right after the last sample is the first sample of the next window, so the dump cycle can itself accept a sample.
- Throughput: one sample per clock. N=1 (dump_len=0) gives one dump per valid sample.
- Reset asserted mid-window discards the window with no dout_valid. After release, the block idles until start.

## Test plan
- Basic dump (SHIFT=8): start with dump_len=3, cont=0, then 4 valid cycles of din_i=1000, din_q=-1000. Required: dout_i=15, dout_q=-16, sat=0, dout_valid high for 1 cycle, one cycle after the 4th sample. busy falls in that same cycle. The block returns to IDLE and further din_valid has no effect.
- Gapped input: same setup as the basic dump, with din_valid=1,0,1,0,0,1,1 and data 1000 on valid cycles only (invalid-cycle data=5000). Required: result identical to the basic dump, dumped after the 7th cycle.
- Continuous, SHIFT=0 instance: start with dump_len=1, cont=1, then din_i=1,2,3,4,5,6 on consecutive valid cycles. Required: dout_i = 3, 7, 11 on three strobes spaced 2 cycles apart; busy stays 1 throughout.
- Saturation, SHIFT=0: dump_len=1, din_i=30000 twice, din_q=-32768 twice. Required: dout_i=32767, dout_q=-32768, sat=1.
- Full-scale window, SHIFT=8: dump_len=255, 256 samples of din_i=-32768 and din_q=32767. Required: dout_i=-32768, dout_q=32767 (floor of 8388352/256 = 32767), sat=0.
- Abort and reset:
  - Start with dump_len=3, feed 2 samples, re-pulse start, then feed 4 samples of 100. Required: a single dump with dout_i=1 (400>>>8).
  - Assert reset after 2 samples. Required: all outputs 0, no dout_valid, busy=0.
